// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding, default
// widths and the iteration counter width.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 24;
  localparam int DIVISOR_W_DEF  = 8;

  // Counter must hold DIVIDEND_W-1; never let it collapse to zero bits.
  function automatic int div_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = div_cnt_w(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, report the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] shifted;

  // Shift/compare/subtract; the extra headroom bit keeps the compare exact.
  always_comb begin
    shifted  = {rem, bit_in};
    q_bit    = (shifted >= {2'b00, divisor});
    rem_next = q_bit ? (DIVISOR_W+1)'(shifted - {2'b00, divisor})
                     : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first.
// Handshake: a transfer happens on a rising edge where valid && ready on the
// same side; in_ready is high only in IDLE, out_valid only in DONE, so an
// input accept and an output release can never share an edge.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output div_state_e            dbg_state
);

  localparam int CW = div_cnt_w(DIVIDEND_W);

  div_state_e            state;
  div_state_e            state_next;
  logic                  accept;
  logic [CW-1:0]         cnt;
  logic [DIVIDEND_W-1:0] dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [DIVISOR_W:0]    rem_next;
  logic                  q_bit;
  logic                  dvs_zero;

  assign dvs_zero  = (dvs_q == '0);
  assign dbg_state = state;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .rem      (rem_q),
    .bit_in   (dvd_q[DIVIDEND_W-1]),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (dvs_zero || (cnt == '0)) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers. Results are
  // only written on the CALC->DONE edge so they stay put in IDLE, CALC and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt   <= CW'(DIVIDEND_W - 1);
          end
        end
        CALC: begin
          if (dvs_zero) begin
            quotient    <= '1;
            remainder   <= dvd_q[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
          end else begin
            dvd_q <= {dvd_q[DIVIDEND_W-2:0], q_bit};
            rem_q <= rem_next;
            cnt   <= cnt - CW'(1);
            if (cnt == '0) begin
              quotient    <= {dvd_q[DIVIDEND_W-2:0], q_bit};
              remainder   <= rem_next[DIVISOR_W-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases with literal expectations plus a
// randomized phase, all checked every cycle against a latency/result model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int DW = 24;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  div_state_e    dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock.
  always #5 clk = ~clk;

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = accepting, 1 = computing, 2 = holding a result.
  logic [DW+VW:0] exp_q[$];
  int             m_mode = 0;
  int             m_cnt  = 0;
  int             m_lat  = 0;
  logic [DW-1:0]  m_q = '0;
  logic [VW-1:0]  m_r = '0;
  logic           m_z = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_q = '0; m_r = '0; m_z = 1'b0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          if (divisor == 0) begin
            exp_q.push_back({1'b1, dividend[VW-1:0], {DW{1'b1}}});
            m_lat = 1;
          end else begin
            exp_q.push_back({1'b0, VW'(dividend % divisor), DW'(dividend / divisor)});
            m_lat = DW;
          end
          m_cnt  = 0;
          m_mode = 1;
        end
        1: begin
          m_cnt++;
          if (m_cnt == m_lat) begin
            {m_z, m_r, m_q} = exp_q.pop_front();
            m_mode = 2;
          end
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("in_ready",    32'(in_ready),    32'(m_mode == 0));
    chk("out_valid",   32'(out_valid),   32'(m_mode == 2));
    chk("quotient",    32'(quotient),    32'(m_q));
    chk("remainder",   32'(remainder),   32'(m_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
  end

  task automatic wait_in_ready(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    chk({name, "_in_ready_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic wait_out_valid(input string name, output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) return;
    end
    chk({name, "_out_valid_timeout"}, 32'(0), 32'(1));
  endtask

  // Drive one operation, check result and latency against literals, release it.
  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                        input logic [DW-1:0] eq, input logic [VW-1:0] er,
                        input logic ez, input int elat, input string name);
    int lat;
    wait_in_ready(name);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid(name, lat);
    chk({name, "_latency"}, 32'(lat), 32'(elat));
    chk({name, "_q"},       32'(quotient), 32'(eq));
    chk({name, "_r"},       32'(remainder), 32'(er));
    chk({name, "_dbz"},     32'(div_by_zero), 32'(ez));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_quotient",  32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_dbz",       32'(div_by_zero), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency counted in negedges after the accept edge: steps + 1.
    run_op(24'h00C800, 8'd8,   24'h001900, 8'd0,   1'b0, DW + 1, "c800_8");
    run_op(24'd1000,   8'd7,   24'd142,    8'd6,   1'b0, DW + 1, "1000_7");
    run_op(24'hFFFFFF, 8'hFF,  24'h010101, 8'd0,   1'b0, DW + 1, "ffffff_ff");
    run_op(24'hFFFFFF, 8'd1,   24'hFFFFFF, 8'd0,   1'b0, DW + 1, "ffffff_1");
    run_op(24'h123456, 8'd0,   24'hFFFFFF, 8'h56,  1'b1, 2,      "dbz");
    run_op(24'd255,    8'd16,  24'd15,     8'd15,  1'b0, DW + 1, "255_16");

    // Backpressure: result held while in_valid toggles with junk operands.
    wait_in_ready("bp");
    in_valid = 1'b1; dividend = 24'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0]; dividend = 24'($urandom); divisor = 8'($urandom);
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_hold_q",   32'(quotient), 32'(142));
      chk("bp_hold_r",   32'(remainder), 32'(6));
    end
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 24'd5000; divisor = 8'd3; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_ready_after_release", 32'(in_ready), 32'(1));
    chk("bp_idle_keeps_q",        32'(quotient), 32'(142));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", 32'(in_ready), 32'(0));
    wait_out_valid("bp2", lat);
    chk("bp2_q", 32'(quotient), 32'(1666));
    chk("bp2_r", 32'(remainder), 32'(2));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a computation.
    wait_in_ready("mid_rst");
    in_valid = 1'b1; dividend = 24'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready",  32'(in_ready), 32'(1));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_q",         32'(quotient), 32'(0));
    chk("mid_rst_r",         32'(remainder), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(24'd1000, 8'd7, 24'd142, 8'd6, 1'b0, DW + 1, "after_rst");

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst       = (i == 1500);
      in_valid  = 1'($urandom_range(0, 1));
      dividend  = 24'($urandom);
      divisor   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 24, dividend and quotient width (matches the 24-bit fixed-point product format).
REQ-002 SHALL have parameter DIVISOR_W, default 8, divisor and remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  dividend/divisor present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port dividend  input  DIVIDEND_W  unsigned dividend.
REQ-008 SHALL have port divisor  input  DIVISOR_W  unsigned divisor.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port quotient  output  DIVIDEND_W  unsigned quotient.
REQ-012 SHALL have port remainder  output  DIVISOR_W  unsigned remainder.
REQ-013 SHALL have port div_by_zero  output  1  result came from divisor == 0.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-015 SHALL assert in_ready only in IDLE and out_valid only in DONE; the two are never high together.
REQ-016 SHALL accept operands on an edge where in_valid && in_ready, latch both operands, clear the partial remainder, load the iteration counter with DIVIDEND_W-1, and go IDLE->CALC.
REQ-017 SHALL perform one radix-2 restoring step per CALC edge, MSB first: shift remainder left with the next dividend bit, subtract the divisor if the result is >= divisor, and shift the result bit into the quotient.
REQ-018 SHALL widen the partial remainder internally to DIVISOR_W+1 bits so the compare never overflows.
REQ-019 SHALL decrement the counter on each step and go CALC->DONE on the step where the counter equals 0, i.e. after exactly DIVIDEND_W steps.
REQ-020 SHALL, for a nonzero divisor, raise out_valid in the cycle after edge DIVIDEND_W+1, counting the accept edge as edge 1 (24 steps for defaults).
REQ-021 SHALL, when the latched divisor is 0, go CALC->DONE on the first CALC edge with quotient = all ones, remainder = dividend[DIVISOR_W-1:0], and div_by_zero = 1.
REQ-022 SHALL clear div_by_zero for every nonzero-divisor result.
REQ-023 SHALL hold quotient, remainder and div_by_zero stable while out_valid && !out_ready.
REQ-024 SHALL go DONE->IDLE on the edge where out_valid && out_ready; in_ready rises in the next cycle, with no same-cycle accept.
REQ-025 SHALL ignore in_valid, dividend and divisor outside IDLE.
REQ-026 SHALL keep quotient, remainder and div_by_zero at their last values in IDLE and CALC.
REQ-027 SHALL guarantee quotient*divisor + remainder == dividend and remainder < divisor for every nonzero divisor.

Reset
REQ-028 SHALL, while rst is high, force state IDLE, in_ready 1, out_valid 0, and quotient, remainder, div_by_zero, counter and internal registers to 0.
REQ-029 SHALL, when rst is asserted in CALC or DONE, abandon the operation with no out_valid pulse; the next operation starts from a clean accept.

Structure
REQ-030 SHALL place the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), the default widths and the counter width CNT_W = clog2(DIVIDEND_W) in shared package div_pkg.
REQ-031 SHALL use one combinational sub-module div_step that performs the shift/compare/subtract and outputs the next remainder and the quotient bit.
REQ-032 SHALL contain no multiplier or "/" operator.

Verification
REQ-033 SHALL cover: dividend 24'h00C800, divisor 8 -> quotient 24'h001900, remainder 0, div_by_zero 0, out_valid after 24 steps.
REQ-034 SHALL cover: dividend 1000, divisor 7 -> quotient 142, remainder 6.
REQ-035 SHALL cover: dividend 24'hFFFFFF, divisor 8'hFF -> quotient 24'h010101, remainder 0; and dividend 24'hFFFFFF, divisor 1 -> quotient 24'hFFFFFF, remainder 0.
REQ-036 SHALL cover: dividend 24'h123456, divisor 0 -> quotient 24'hFFFFFF, remainder 8'h56, div_by_zero 1, out_valid in the cycle after the first CALC edge.
REQ-037 SHALL cover: out_ready held low 10 cycles with in_valid toggling -> outputs stable, in_ready 0, no operand captured; the accept happens only after the out handshake plus one cycle.
REQ-038 SHALL cover: rst pulsed at the 10th CALC step -> all outputs 0, in_ready 1, then a fresh 1000/7 gives 142 rem 6.
